// File: rtl/mem_arb_pkg.sv
// Shared types, widths and the byte-merge helper for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 8;
  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned STRB_W         = MEM_DATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    RMW
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_LS
  } grant_e;

  // Byte-wise select: strobed bytes come from new_word, the rest from old_word.
  function automatic logic [MEM_DATA_WIDTH-1:0] merge_bytes(
    input logic [MEM_DATA_WIDTH-1:0] old_word,
    input logic [MEM_DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]         strb
  );
    logic [MEM_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Fetch port, load/store port and memory-side signals of the arbiter.
interface mem_arb_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    if_req_valid;
  logic                    if_req_ready;
  logic [ADDR_WIDTH-1:0]   if_req_addr;
  logic                    if_rsp_valid;
  logic                    if_rsp_ready;
  logic [DATA_WIDTH-1:0]   if_rsp_data;

  logic                    ls_req_valid;
  logic                    ls_req_ready;
  logic [ADDR_WIDTH-1:0]   ls_req_addr;
  logic                    ls_req_we;
  logic [DATA_WIDTH/8-1:0] ls_req_wstrb;
  logic [DATA_WIDTH-1:0]   ls_req_wdata;
  logic                    ls_rsp_valid;
  logic                    ls_rsp_ready;
  logic [DATA_WIDTH-1:0]   ls_rsp_data;

  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic                    mem_write_enable;
  logic [DATA_WIDTH-1:0]   mem_data_out;

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wstrb, ls_req_wdata, ls_rsp_ready,
    input  mem_data_out,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_addr, mem_data_in, mem_write_enable
  );

  // Core / memory side.
  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wstrb, ls_req_wdata, ls_rsp_ready,
    output mem_data_out,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_addr, mem_data_in, mem_write_enable
  );

endinterface

// File: rtl/mem_arb_rsp_slot.sv
// Single-entry response holding register: loads on load_i, drains on ready_i.
module mem_arb_rsp_slot #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // A load always wins: the arbiter only loads when the slot is empty or draining.
  always_comb begin
    valid_d = valid_q & ~ready_i;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store,
// with read-modify-write for sub-word stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_WIDTH-1:0] rmw_data_q, rmw_data_d;

  grant_e                grant;
  logic                  if_elig, ls_elig;
  logic                  ls_full, ls_null, ls_partial;
  logic [ADDR_WIDTH-1:0] if_word_addr, ls_word_addr;
  logic [DATA_WIDTH-1:0] merged;
  logic                  if_load, ls_load;
  logic [DATA_WIDTH-1:0] ls_load_data;
  logic                  if_rsp_valid, ls_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rsp_data, ls_rsp_data;

  assign if_word_addr = {bus.if_req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign ls_word_addr = {bus.ls_req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign ls_full      = &bus.ls_req_wstrb;
  assign ls_null      = ~|bus.ls_req_wstrb;
  assign ls_partial   = ~ls_full & ~ls_null;
  assign merged       = DATA_WIDTH'(merge_bytes(MEM_DATA_WIDTH'(bus.mem_data_out),
                                                MEM_DATA_WIDTH'(bus.ls_req_wdata),
                                                STRB_W'(bus.ls_req_wstrb)));

  // Grant decision; a requester may win when its response slot is free or draining.
  always_comb begin
    if_elig = bus.if_req_valid && (!if_rsp_valid || bus.if_rsp_ready);
    ls_elig = bus.ls_req_valid && (!ls_rsp_valid || bus.ls_rsp_ready);
    grant   = GNT_NONE;
    if (rst_n && state_q == IDLE) begin
      if (if_elig && ls_elig) begin
        grant = (last_grant_q == GNT_IF) ? GNT_LS : GNT_IF;
      end else if (if_elig) begin
        grant = GNT_IF;
      end else if (ls_elig) begin
        grant = GNT_LS;
      end
    end
    bus.if_req_ready = (grant == GNT_IF);
    bus.ls_req_ready = (grant == GNT_LS);
  end

  // Memory-side mux: granted request, or the merged write-back during RMW.
  always_comb begin
    bus.mem_addr         = '0;
    bus.mem_data_in      = bus.ls_req_wdata;
    bus.mem_write_enable = 1'b0;
    if (grant == GNT_IF) begin
      bus.mem_addr = if_word_addr;
    end else if (grant == GNT_LS) begin
      bus.mem_addr         = ls_word_addr;
      bus.mem_write_enable = bus.ls_req_we && ls_full;
    end else if (rst_n && state_q == RMW) begin
      bus.mem_addr         = rmw_addr_q;
      bus.mem_data_in      = rmw_data_q;
      bus.mem_write_enable = 1'b1;
    end
  end

  // Next state, RMW capture and response-slot loads.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_data_d   = rmw_data_q;
    if (grant != GNT_NONE) begin
      last_grant_d = grant;
    end
    if (state_q == RMW) begin
      state_d = IDLE;
    end else if (grant == GNT_LS && bus.ls_req_we && ls_partial) begin
      state_d    = RMW;
      rmw_addr_d = ls_word_addr;
      rmw_data_d = merged;
    end

    if_load = (grant == GNT_IF);
    ls_load = (grant == GNT_LS && !(bus.ls_req_we && ls_partial)) || (state_q == RMW);
    if (state_q == RMW) begin
      ls_load_data = rmw_data_q;
    end else if (bus.ls_req_we && ls_full) begin
      ls_load_data = bus.ls_req_wdata;
    end else begin
      // Loads and null stores both return the word currently in memory.
      ls_load_data = bus.mem_data_out;
    end
  end

  // Arbiter state registers; reset drops any in-flight RMW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      rmw_addr_q   <= '0;
      rmw_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_data_q   <= rmw_data_d;
    end
  end

  mem_arb_rsp_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_slot (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (if_load),
    .data_i (bus.mem_data_out),
    .ready_i(bus.if_rsp_ready),
    .valid_o(if_rsp_valid),
    .data_o (if_rsp_data)
  );

  mem_arb_rsp_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ls_slot (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (ls_load),
    .data_i (ls_load_data),
    .ready_i(bus.ls_rsp_ready),
    .valid_o(ls_rsp_valid),
    .data_o (ls_rsp_data)
  );

  assign bus.if_rsp_valid = if_rsp_valid;
  assign bus.if_rsp_data  = if_rsp_data;
  assign bus.ls_rsp_valid = ls_rsp_valid;
  assign bus.ls_rsp_data  = ls_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// word-level memory model with per-port response queues.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arb_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural single-port memory: combinational read, write on posedge.
  logic [31:0] tb_mem [64] = '{default: 32'h0};
  assign bus.mem_data_out = tb_mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_write_enable) tb_mem[bus.mem_addr[7:2]] <= bus.mem_data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state.
  typedef struct {
    logic [31:0] data;
    int unsigned rdy;
  } rsp_t;
  rsp_t        if_q[$];
  rsp_t        ls_q[$];
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  bit          busy = 0;
  logic [5:0]  pend_idx;
  logic [31:0] pend_data;
  bit          last_ls = 0;
  int unsigned cyc = 0;
  logic        rst_prev = 1'b0;

  // Per-cycle model check, sampled mid-cycle after the negedge drive.
  initial begin : monitor
    forever begin
      logic if_vis, ls_vis, e_if, e_ls, g_if, g_ls;
      logic [5:0]  idx;
      logic [31:0] old_w, mrg;
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        n_total++;
        if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0 ||
            bus.mem_write_enable !== 1'b0 || bus.mem_addr !== 8'h00)
          $display("FAIL mon_reset_outputs: if_rdy=%b ls_rdy=%b we=%b addr=%h, want all 0",
                   bus.if_req_ready, bus.ls_req_ready, bus.mem_write_enable, bus.mem_addr);
        else n_pass++;
        if (rst_prev === 1'b0) begin
          n_total++;
          if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0)
            $display("FAIL mon_reset_rsp: if_v=%b ls_v=%b, want 0 0",
                     bus.if_rsp_valid, bus.ls_rsp_valid);
          else n_pass++;
        end
        if_q.delete();
        ls_q.delete();
        busy    = 0;
        last_ls = 0;
      end else begin
        if_vis = (if_q.size() != 0) && (if_q[0].rdy <= cyc);
        ls_vis = (ls_q.size() != 0) && (ls_q[0].rdy <= cyc);
        n_total++;
        if (bus.if_rsp_valid !== if_vis || (if_vis && bus.if_rsp_data !== if_q[0].data))
          $display("FAIL mon_if_rsp: cyc %0d valid=%b data=%h, want valid=%b data=%h", cyc,
                   bus.if_rsp_valid, bus.if_rsp_data, if_vis, if_vis ? if_q[0].data : 32'h0);
        else n_pass++;
        n_total++;
        if (bus.ls_rsp_valid !== ls_vis || (ls_vis && bus.ls_rsp_data !== ls_q[0].data))
          $display("FAIL mon_ls_rsp: cyc %0d valid=%b data=%h, want valid=%b data=%h", cyc,
                   bus.ls_rsp_valid, bus.ls_rsp_data, ls_vis, ls_vis ? ls_q[0].data : 32'h0);
        else n_pass++;

        e_if = !busy && bus.if_req_valid && (!if_vis || bus.if_rsp_ready);
        e_ls = !busy && bus.ls_req_valid && (!ls_vis || bus.ls_rsp_ready);
        if (e_if && e_ls) begin
          g_if = last_ls;
          g_ls = !last_ls;
        end else begin
          g_if = e_if;
          g_ls = e_ls;
        end
        n_total++;
        if (bus.if_req_ready !== g_if || bus.ls_req_ready !== g_ls)
          $display("FAIL mon_grant: cyc %0d if_rdy=%b ls_rdy=%b, want %b %b", cyc,
                   bus.if_req_ready, bus.ls_req_ready, g_if, g_ls);
        else n_pass++;

        if (if_vis && bus.if_rsp_ready) void'(if_q.pop_front());
        if (ls_vis && bus.ls_rsp_ready) void'(ls_q.pop_front());

        if (busy) begin
          n_total++;
          if (bus.mem_write_enable !== 1'b1 || bus.mem_addr !== {pend_idx, 2'b00} ||
              bus.mem_data_in !== pend_data)
            $display("FAIL mon_rmw_write: we=%b addr=%h data=%h, want 1 %h %h",
                     bus.mem_write_enable, bus.mem_addr, bus.mem_data_in,
                     {pend_idx, 2'b00}, pend_data);
          else n_pass++;
          ref_mem[pend_idx] = pend_data;
          ls_q.push_back('{data: pend_data, rdy: cyc + 1});
          busy = 0;
        end
        if (g_if) begin
          if_q.push_back('{data: ref_mem[bus.if_req_addr[7:2]], rdy: cyc + 1});
          last_ls = 0;
        end
        if (g_ls) begin
          last_ls = 1;
          idx     = bus.ls_req_addr[7:2];
          old_w   = ref_mem[idx];
          if (!bus.ls_req_we) begin
            ls_q.push_back('{data: old_w, rdy: cyc + 1});
          end else begin
            mrg = old_w;
            for (int b = 0; b < 4; b++)
              if (bus.ls_req_wstrb[b]) mrg[8*b +: 8] = bus.ls_req_wdata[8*b +: 8];
            if (bus.ls_req_wstrb == 4'hF || bus.ls_req_wstrb == 4'h0) begin
              ref_mem[idx] = mrg;
              ls_q.push_back('{data: mrg, rdy: cyc + 1});
            end else begin
              busy      = 1;
              pend_idx  = idx;
              pend_data = mrg;
            end
          end
        end
      end
      rst_prev = rst_n;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = 8'h00;
    bus.ls_req_valid = 1'b0;
    bus.ls_req_addr  = 8'h00;
    bus.ls_req_we    = 1'b0;
    bus.ls_req_wstrb = 4'h0;
    bus.ls_req_wdata = 32'h0;
    bus.if_rsp_ready = 1'b1;
    bus.ls_rsp_ready = 1'b1;
  endtask

  task automatic if_read(input logic [7:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = a;
    bus.if_rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.if_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    #1;
    while (!bus.if_rsp_valid && n < 40) begin
      @(negedge clk); #1; n++;
    end
    d = bus.if_rsp_data;
    if (n >= 40) begin
      n_total++;
      $display("FAIL if_read_timeout: addr %h no response, want one within 40 cycles", a);
    end
  endtask

  task automatic ls_access(input logic [7:0] a, input logic we, input logic [3:0] strb,
                           input logic [31:0] wd, output logic [31:0] d);
    int n;
    @(negedge clk);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = a;
    bus.ls_req_we    = we;
    bus.ls_req_wstrb = strb;
    bus.ls_req_wdata = wd;
    bus.ls_rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.ls_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    bus.ls_req_valid = 1'b0;
    #1;
    while (!bus.ls_rsp_valid && n < 40) begin
      @(negedge clk); #1; n++;
    end
    d = bus.ls_rsp_data;
    if (n >= 40) begin
      n_total++;
      $display("FAIL ls_access_timeout: addr %h no response, want one within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle_inputs();
    rst_n = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b1;
    bus.ls_req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0 || bus.if_req_ready !== 1'b0 ||
          bus.ls_req_ready !== 1'b0 || bus.mem_write_enable !== 1'b0)
        $display("FAIL reset_state: rspv=%b%b rdy=%b%b we=%b, want all 0", bus.if_rsp_valid,
                 bus.ls_rsp_valid, bus.if_req_ready, bus.ls_req_ready, bus.mem_write_enable);
      else n_pass++;
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    if_read(8'h04, d);
    n_total++;
    if (d !== 32'h0000_0000) $display("FAIL reset_first_read: got %h want 00000000", d);
    else n_pass++;
  endtask

  task automatic test_full_store();
    logic [31:0] d;
    ls_access(8'h08, 1'b1, 4'hF, 32'hDEAD_BEEF, d);
    n_total++;
    if (d !== 32'hDEAD_BEEF) $display("FAIL full_store_ack: got %h want deadbeef", d);
    else n_pass++;
    if_read(8'h08, d);
    n_total++;
    if (d !== 32'hDEAD_BEEF) $display("FAIL full_store_readback: got %h want deadbeef", d);
    else n_pass++;
  endtask

  task automatic test_alternation();
    logic exp_ls;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b0;
    exp_ls = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.if_req_addr = 8'($urandom_range(0, 63)) & 8'hFC;
      bus.ls_req_addr = 8'($urandom_range(0, 63));
      #1;
      n_total++;
      if (bus.ls_req_ready !== exp_ls || bus.if_req_ready !== ~exp_ls)
        $display("FAIL alternation: step %0d ls_rdy=%b if_rdy=%b, want %b %b", i,
                 bus.ls_req_ready, bus.if_req_ready, exp_ls, ~exp_ls);
      else n_pass++;
      exp_ls = ~exp_ls;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_partial_store();
    logic [31:0] d;
    @(negedge clk);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 8'h09;
    bus.ls_req_we    = 1'b1;
    bus.ls_req_wstrb = 4'b0010;
    bus.ls_req_wdata = 32'h0000_AA00;
    #1;
    n_total++;
    if (bus.ls_req_ready !== 1'b1) $display("FAIL rmw_grant: ls_rdy=%b want 1", bus.ls_req_ready);
    else n_pass++;
    @(negedge clk);
    bus.ls_req_valid = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h04;
    #1;
    n_total++;
    if (bus.if_req_ready !== 1'b0 || bus.ls_rsp_valid !== 1'b0)
      $display("FAIL rmw_busy: if_rdy=%b ls_rspv=%b, want 0 0", bus.if_req_ready,
               bus.ls_rsp_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_data !== 32'hDEAD_AAEF)
      $display("FAIL rmw_rsp: valid=%b data=%h, want 1 deadaaef", bus.ls_rsp_valid,
               bus.ls_rsp_data);
    else n_pass++;
    n_total++;
    if (bus.if_req_ready !== 1'b1) $display("FAIL rmw_release: if_rdy=%b want 1",
                                            bus.if_req_ready);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    if_read(8'h08, d);
    n_total++;
    if (d !== 32'hDEAD_AAEF) $display("FAIL rmw_readback: got %h want deadaaef", d);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    @(negedge clk);
    bus.if_rsp_ready = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h08;
    #1;
    n_total++;
    if (bus.if_req_ready !== 1'b1) $display("FAIL bp_accept: if_rdy=%b want 1", bus.if_req_ready);
    else n_pass++;
    @(negedge clk);
    bus.if_req_addr  = 8'h0C;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b0;
    bus.ls_req_addr  = 8'h04;
    held = 32'hDEAD_AAEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== held || bus.if_req_ready !== 1'b0 ||
          bus.ls_req_ready !== 1'b1)
        $display("FAIL backpressure: cyc %0d if_v=%b if_d=%h if_rdy=%b ls_rdy=%b, want 1 %h 0 1",
                 i, bus.if_rsp_valid, bus.if_rsp_data, bus.if_req_ready, bus.ls_req_ready, held);
      else n_pass++;
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_rmw();
    logic [31:0] d;
    @(negedge clk);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 8'h08;
    bus.ls_req_we    = 1'b1;
    bus.ls_req_wstrb = 4'b0001;
    bus.ls_req_wdata = 32'h0000_0011;
    #1;
    n_total++;
    if (bus.ls_req_ready !== 1'b1) $display("FAIL rst_rmw_grant: ls_rdy=%b want 1",
                                            bus.ls_req_ready);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_total++;
    if (bus.ls_rsp_valid !== 1'b0) $display("FAIL rst_rmw_rsp: ls_rspv=%b want 0",
                                            bus.ls_rsp_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    if_read(8'h08, d);
    n_total++;
    if (d !== 32'hDEAD_AAEF) $display("FAIL rst_rmw_mem: got %h want deadaaef", d);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.if_req_valid = 1'($urandom_range(0, 1));
      bus.if_req_addr  = 8'($urandom_range(0, 31));
      bus.if_rsp_ready = ($urandom_range(0, 3) != 0);
      bus.ls_req_valid = 1'($urandom_range(0, 1));
      bus.ls_req_addr  = 8'($urandom_range(0, 31));
      bus.ls_req_we    = 1'($urandom_range(0, 1));
      bus.ls_req_wstrb = 4'($urandom_range(0, 15));
      bus.ls_req_wdata = $urandom;
      bus.ls_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
  endtask

  initial begin : main
    test_reset();
    test_full_store();
    test_alternation();
    test_partial_store();
    test_backpressure();
    test_reset_in_rmw();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
